// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: widths, maskmode codes
// and the arbitration state encoding.
package dmem_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REQ    = 2;

  // The data memory decodes the same maskmode values.
  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_LOCK0 = 2'b01,
    ARB_LOCK1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory port around the arbiter.
// The slave view belongs to the arbiter; the master view to requesters and memory.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic                  req0, req1;
  logic                  lock0, lock1;
  logic                  we0, we1;
  logic [1:0]            mask0, mask1;
  logic                  sext0, sext1;
  logic [DATA_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;

  logic                  mem_write, mem_read;
  logic [1:0]            mem_maskmode;
  logic                  mem_sext;
  logic [DATA_WIDTH-1:0] mem_address, mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, mask0, mask1,
           sext0, sext1, addr0, addr1, wdata0, wdata1, mem_read_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_write, mem_read, mem_maskmode, mem_sext,
           mem_address, mem_write_data
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, mask0, mask1,
           sext0, sext1, addr0, addr1, wdata0, wdata1, mem_read_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_write, mem_read, mem_maskmode, mem_sext,
           mem_address, mem_write_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last. win is the winning port index.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win
);

  assign win = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU port (0) and the DMA port (1) with
// round-robin fairness and a lock for atomic multi-access sequences.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  arb_state_t            state_q, state_d;
  logic                  last_q, last_d;
  logic                  win;
  logic                  gnt0, gnt1;
  logic                  mem_write, mem_read;
  logic [1:0]            mem_maskmode;
  logic                  mem_sext;
  logic [DATA_WIDTH-1:0] mem_address, mem_write_data;
  logic                  rvalid0_q, rvalid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  rr_arb2 u_rr_arb2 (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .last (last_q),
    .win  (win)
  );

  // Reset leaves port 1 as last winner so port 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
    case (state_q)
      ARB_IDLE: begin
        if (gnt0 && bus.lock0)      state_d = ARB_LOCK0;
        else if (gnt1 && bus.lock1) state_d = ARB_LOCK1;
      end
      ARB_LOCK0: if (gnt0 && !bus.lock0) state_d = ARB_IDLE;
      ARB_LOCK1: if (gnt1 && !bus.lock1) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // A locked owner with no request simply keeps the bus idle; there is no timeout.
  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    mem_maskmode   = 2'b00;
    mem_sext       = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (rst_n) begin
      case (state_q)
        ARB_IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt0 = ~win;
            gnt1 = win;
          end
        end
        ARB_LOCK0: gnt0 = bus.req0;
        ARB_LOCK1: gnt1 = bus.req1;
        default: ;
      endcase
    end
    if (gnt0) begin
      mem_write      = bus.we0;
      mem_read       = ~bus.we0;
      mem_maskmode   = bus.mask0;
      mem_sext       = bus.sext0;
      mem_address    = bus.addr0;
      mem_write_data = bus.wdata0;
    end else if (gnt1) begin
      mem_write      = bus.we1;
      mem_read       = ~bus.we1;
      mem_maskmode   = bus.mask1;
      mem_sext       = bus.sext1;
      mem_address    = bus.addr1;
      mem_write_data = bus.wdata1;
    end
  end

  // Load data is captured at the edge closing the grant cycle; rdata holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 && !bus.we0;
      rvalid1_q <= gnt1 && !bus.we1;
      if (gnt0 && !bus.we0) rdata0_q <= bus.mem_read_data;
      if (gnt1 && !bus.we1) rdata1_q <= bus.mem_read_data;
    end
  end

  assign bus.gnt0           = gnt0;
  assign bus.gnt1           = gnt1;
  assign bus.rvalid0        = rvalid0_q;
  assign bus.rvalid1        = rvalid1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;
  assign bus.mem_write      = mem_write;
  assign bus.mem_read       = mem_read;
  assign bus.mem_maskmode   = mem_maskmode;
  assign bus.mem_sext       = mem_sext;
  assign bus.mem_address    = mem_address;
  assign bus.mem_write_data = mem_write_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed memory model
// (combinational read, store committed on the falling edge).
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mem [16];

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory read path: extract by offset, then sign/zero extend (sext=1 is unsigned).
  always_comb begin
    logic [31:0] word;
    logic [31:0] shifted;
    word    = mem[bus.mem_address[5:2]];
    shifted = word >> (8 * bus.mem_address[1:0]);
    case (bus.mem_maskmode)
      MASK_BYTE: bus.mem_read_data = bus.mem_sext ? {24'h0, shifted[7:0]}
                                                  : {{24{shifted[7]}}, shifted[7:0]};
      MASK_HALF: bus.mem_read_data = bus.mem_sext ? {16'h0, shifted[15:0]}
                                                  : {{16{shifted[15]}}, shifted[15:0]};
      default:   bus.mem_read_data = word;
    endcase
  end

  always @(negedge clk) begin
    if (bus.mem_write) begin
      case (bus.mem_maskmode)
        MASK_BYTE: begin
          case (bus.mem_address[1:0])
            2'd0: mem[bus.mem_address[5:2]][7:0]   <= bus.mem_write_data[7:0];
            2'd1: mem[bus.mem_address[5:2]][15:8]  <= bus.mem_write_data[7:0];
            2'd2: mem[bus.mem_address[5:2]][23:16] <= bus.mem_write_data[7:0];
            default: mem[bus.mem_address[5:2]][31:24] <= bus.mem_write_data[7:0];
          endcase
        end
        MASK_HALF: begin
          if (bus.mem_address[1]) mem[bus.mem_address[5:2]][31:16] <= bus.mem_write_data[15:0];
          else                    mem[bus.mem_address[5:2]][15:0]  <= bus.mem_write_data[15:0];
        end
        default: mem[bus.mem_address[5:2]] <= bus.mem_write_data;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic lock,
                               input logic we, input logic [1:0] mask, input logic sext,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0 = req; bus.lock0 = lock; bus.we0 = we; bus.mask0 = mask;
      bus.sext0 = sext; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = req; bus.lock1 = lock; bus.we1 = we; bus.mask1 = mask;
      bus.sext1 = sext; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4]  = 32'h1234_5678;
    mem[8]  = 32'h0000_80FF;
    mem[12] = 32'hCAFE_F00D;
    rst_n = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h0, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h10, 32'h0);

    // Reset state, request present but gated.
    #12;
    checkOutput("rst_gnt0", {31'h0, bus.gnt0}, 32'h0);
    checkOutput("rst_mem_read", {31'h0, bus.mem_read}, 32'h0);
    checkOutput("rst_rvalid0", {31'h0, bus.rvalid0}, 32'h0);
    checkOutput("rst_rvalid1", {31'h0, bus.rvalid1}, 32'h0);
    checkOutput("rst_rdata0", bus.rdata0, 32'h0);

    // Single port-0 word load.
    nextCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("ld_gnt0", {31'h0, bus.gnt0}, 32'h1);
    checkOutput("ld_gnt1", {31'h0, bus.gnt1}, 32'h0);
    checkOutput("ld_mem_read", {31'h0, bus.mem_read}, 32'h1);
    checkOutput("ld_mem_write", {31'h0, bus.mem_write}, 32'h0);
    checkOutput("ld_mem_address", bus.mem_address, 32'h10);
    nextCycle();
    checkOutput("ld_rvalid0", {31'h0, bus.rvalid0}, 32'h1);
    checkOutput("ld_rdata0", bus.rdata0, 32'h1234_5678);
    checkOutput("ld_rvalid1", {31'h0, bus.rvalid1}, 32'h0);

    // Port-1 byte store.
    applyStimulus(0, 1'b0, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b1, MASK_BYTE, 1'b0, 32'h20, 32'h0000_00AB);
    #1;
    checkOutput("st_gnt1", {31'h0, bus.gnt1}, 32'h1);
    checkOutput("st_mem_write", {31'h0, bus.mem_write}, 32'h1);
    checkOutput("st_mem_read", {31'h0, bus.mem_read}, 32'h0);
    checkOutput("st_mask", {30'h0, bus.mem_maskmode}, 32'h0);
    checkOutput("st_wdata", bus.mem_write_data, 32'h0000_00AB);
    nextCycle();
    checkOutput("st_rvalid1", {31'h0, bus.rvalid1}, 32'h0);

    // Continuous double request: port 1 won last, so grants run 0,1,0,1.
    applyStimulus(0, 1'b1, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h30, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("rr_gnt0_%0d", k), {31'h0, bus.gnt0}, (k % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("rr_gnt1_%0d", k), {31'h0, bus.gnt1}, (k % 2 == 1) ? 32'h1 : 32'h0);
      nextCycle();
      checkOutput($sformatf("rr_rvalid0_%0d", k), {31'h0, bus.rvalid0}, (k % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("rr_rvalid1_%0d", k), {31'h0, bus.rvalid1}, (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k % 2 == 0) checkOutput($sformatf("rr_rdata0_%0d", k), bus.rdata0, 32'h1234_5678);
      else            checkOutput($sformatf("rr_rdata1_%0d", k), bus.rdata1, 32'hCAFE_F00D);
    end

    // Signed half-word load over the stored byte.
    applyStimulus(1, 1'b0, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h0, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, MASK_HALF, 1'b0, 32'h20, 32'h0);
    #1;
    checkOutput("half_gnt0", {31'h0, bus.gnt0}, 32'h1);
    nextCycle();
    checkOutput("half_rvalid0", {31'h0, bus.rvalid0}, 32'h1);
    checkOutput("half_rdata0", bus.rdata0, 32'hFFFF_80AB);

    // Port-1 locked load / store / unlocking store while port 0 waits.
    applyStimulus(0, 1'b1, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, MASK_WORD, 1'b0, 32'h30, 32'h0);
    #1;
    checkOutput("lk_ld_gnt1", {31'h0, bus.gnt1}, 32'h1);
    checkOutput("lk_ld_gnt0", {31'h0, bus.gnt0}, 32'h0);
    nextCycle();
    checkOutput("lk_rvalid1", {31'h0, bus.rvalid1}, 32'h1);
    checkOutput("lk_rdata1", bus.rdata1, 32'hCAFE_F00D);
    applyStimulus(1, 1'b1, 1'b1, 1'b1, MASK_WORD, 1'b0, 32'h30, 32'h1122_3344);
    #1;
    checkOutput("lk_st1_gnt1", {31'h0, bus.gnt1}, 32'h1);
    checkOutput("lk_st1_gnt0", {31'h0, bus.gnt0}, 32'h0);
    checkOutput("lk_st1_mem_write", {31'h0, bus.mem_write}, 32'h1);
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 1'b1, MASK_WORD, 1'b0, 32'h30, 32'h5566_7788);
    #1;
    checkOutput("lk_st2_gnt1", {31'h0, bus.gnt1}, 32'h1);
    checkOutput("lk_st2_gnt0", {31'h0, bus.gnt0}, 32'h0);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h0, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h30, 32'h0);
    #1;
    checkOutput("unlk_gnt0", {31'h0, bus.gnt0}, 32'h1);
    nextCycle();
    checkOutput("unlk_rdata0", bus.rdata0, 32'h5566_7788);

    // Reset in the cycle after a granted load.
    applyStimulus(0, 1'b1, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h10, 32'h0);
    #1;
    checkOutput("pre_rst_gnt0", {31'h0, bus.gnt0}, 32'h1);
    nextCycle();
    checkOutput("pre_rst_rvalid0", {31'h0, bus.rvalid0}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rvalid0", {31'h0, bus.rvalid0}, 32'h0);
    checkOutput("mid_rst_gnt0", {31'h0, bus.gnt0}, 32'h0);
    checkOutput("mid_rst_mem_read", {31'h0, bus.mem_read}, 32'h0);
    nextCycle();
    checkOutput("mid_rst_rvalid0_b", {31'h0, bus.rvalid0}, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h30, 32'h0);
    #1;
    checkOutput("post_rst_rvalid0", {31'h0, bus.rvalid0}, 32'h0);
    checkOutput("post_rst_tie_gnt0", {31'h0, bus.gnt0}, 32'h1);
    checkOutput("post_rst_tie_gnt1", {31'h0, bus.gnt1}, 32'h0);
    nextCycle();
    checkOutput("post_rst_rdata0", bus.rdata0, 32'h1234_5678);

    // Idle cycles: nothing granted, rdata holds.
    applyStimulus(0, 1'b0, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput($sformatf("idle_gnt0_%0d", k), {31'h0, bus.gnt0}, 32'h0);
      checkOutput($sformatf("idle_gnt1_%0d", k), {31'h0, bus.gnt1}, 32'h0);
      checkOutput($sformatf("idle_mem_read_%0d", k), {31'h0, bus.mem_read}, 32'h0);
      checkOutput($sformatf("idle_mem_write_%0d", k), {31'h0, bus.mem_write}, 32'h0);
      checkOutput($sformatf("idle_rvalid0_%0d", k), {31'h0, bus.rvalid0}, 32'h0);
      checkOutput($sformatf("idle_rdata0_%0d", k), bus.rdata0, 32'h1234_5678);
    end

    // Still in IDLE: a tie now goes to port 1 since port 0 won last.
    applyStimulus(0, 1'b1, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, MASK_WORD, 1'b0, 32'h30, 32'h0);
    #1;
    checkOutput("final_tie_gnt1", {31'h0, bus.gnt1}, 32'h1);
    checkOutput("final_tie_gnt0", {31'h0, bus.gnt0}, 32'h0);
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data memory between the CPU load/store port (port 0) and the DMA/loader port (port 1). It sits directly in front of the data memory and drives its mem_write/mem_read/maskmode/sext/address/write_data inputs from whichever requester holds the grant. The arbiter also registers read_data back to the winning requester. It provides round-robin fairness and a lock mechanism for atomic multi-access sequences such as read-modify-write.

## Interface
- DATA_WIDTH, 32, data and address width
- NUM_REQ, 2, number of requesters (fixed at 2 in this revision)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous reset, active-low
- req0 / req1  in  1  access request from port 0 / port 1
- lock0 / lock1  in  1  hold the grant after this access
- we0 / we1  in  1  1 = store, 0 = load
- mask0 / mask1  in  2  maskmode: 00 byte, 01 half, 10 word
- sext0 / sext1  in  1  1 = unsigned load (memory sext encoding)
- addr0 / addr1  in  DATA_WIDTH  byte address
- wdata0 / wdata1  in  DATA_WIDTH  store data
- gnt0 / gnt1  out  1  access accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  load data valid (registered)
- rdata0 / rdata1  out  DATA_WIDTH  load result (registered)
- mem_write, mem_read  out  1  to data memory
- mem_maskmode  out  2  to data memory
- mem_sext  out  1  to data memory
- mem_address, mem_write_data  out  DATA_WIDTH  to data memory
- mem_read_data  in  DATA_WIDTH  from data memory (combinational read)

## Operation
- At most one access per cycle. Winner fields are muxed combinationally to the memory.
- On a granted load: mem_read=1. On a granted store: mem_write=1. With no grant, both are 0 and address/data are 0.
- Requester holds req and all fields stable until it sees gnt high in the same cycle. A request is consumed in the cycle gnt=1.
- Arbitration is tracked by the state machine and the last-grant pointer `last`.
  - IDLE: if only one req, grant it. If both, grant the port ≠ last. On grant, last ← winner. If the winner's lock=1, go to LOCKn.
  - LOCK0 / LOCK1: only the owner may be granted, and the other port waits. If the owner is granted with lock=0, return to IDLE. If the owner is granted with lock=1, stay. If the owner has no req, stay; there is no timeout.
- Load return: at the rising edge ending a granted load cycle, rdataN ← mem_read_data and rvalidN ← 1 for exactly one cycle. Otherwise rvalidN ← 0 and rdataN holds its value.
- A store produces no rvalid.
- Sign/zero extension and masking are done by the memory. The arbiter passes mask/sext unchanged.
- Reset values: state=IDLE, last=1 (port 0 wins the first tie), rvalid0=rvalid1=0, rdata0=rdata1=0.
  - gnt and the mem_* outputs are combinational, and are 0 while rst_n=0.

## Timing
- Grant latency: 0 cycles (gnt is in the same cycle as req if that port wins).
- Load latency: rvalid is asserted 1 cycle after gnt.
- Store: the memory commits at the falling edge inside the grant cycle.
- Throughput: 1 access/cycle. Back-to-back grants to alternating or same ports are allowed.
- Simultaneous req0 and req1 in IDLE: round-robin applies. A continuous double request alternates 0,1,0,1.
- Lock asserted on the other port while in LOCKn is ignored until that port is granted from IDLE.
- Reset asserted mid-operation: a pending rvalid is dropped, the lock is released, and no memory access occurs while rst_n=0.

## Structure
- Shared package: the maskmode constants (MASK_BYTE=2'b00, MASK_HALF=2'b01, MASK_WORD=2'b10) and the arbiter state encoding (ARB_IDLE, ARB_LOCK0, ARB_LOCK1). The data memory uses the same maskmode constants.
- One natural sub-module: rr_arb2. It contains a 2-way round-robin pick with a last-grant input and a winner output.
- The FSM, the request mux, and the return registers stay in dmem_arbiter.

## Test plan
- Reset then req0 only (load, word, addr 0x10, memory word 0x1234_5678): gnt0=1 in the same cycle, mem_read=1, mem_address=0x10. Next cycle rvalid0=1, rdata0=0x1234_5678, rvalid1=0.
- req0 and req1 held high for 4 cycles (loads): grants go 0,1,0,1. Each rvalid appears one cycle after its grant.
- req1 store, byte, addr 0x20, wdata 0xAB, with req0 idle: mem_write=1, mem_maskmode=00. A subsequent port 0 half-word load from 0x20 (sext=0) over prior 0x0000_80FF returns 0xFFFF_80AB.
- Port 1 lock sequence: load 0x30 with lock1=1, while req0 is held high. Port 1 then stores with lock1=1, then stores with lock1=0. gnt0 stays 0 for all three, and gnt0=1 in the cycle after the unlock.
- Assert rst_n=0 in the cycle after a granted load: rvalid is 0 during and after reset, and the next tie is won by port 0.
- No requests for 3 cycles: mem_read=mem_write=0, gnt0=gnt1=0, state stays IDLE, and rdata holds its last value.
